// File: rtl/multi_booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the window-to-digit recoding function.
package multi_booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_e;

  // Window is {b[2i+1], b[2i], b[2i-1]}
  function automatic digit_e booth_digit(input logic [2:0] win);
    digit_e d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth encoder: turns a 3-bit multiplier window and the extended
// multiplicand into a signed partial product (0, +-M, +-2M).
module booth_r4_enc
  import multi_booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  assign m1 = {m[WIDTH+1], m};
  assign m2 = {m, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_digit(win))
      POS1:    pp = m1;
      POS2:    pp = m2;
      NEG1:    pp = -m1;
      NEG2:    pp = -m2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/multi_booth_r4_seq.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per cycle,
// fixed latency of WIDTH/2+1 steps, signed or unsigned per operation.
module multi_booth_r4_seq
  import multi_booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               rdy,
  output logic [2*WIDTH-1:0] p
);

  localparam int N    = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int PPW  = WIDTH + 3;
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CNTW = $clog2(N + 1);

  state_e             state_q, state_d;
  logic [EW-1:0]      m_q, m_d;
  logic [EW:0]        b_q, b_d;
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [PPW-1:0]     pp;
  logic [ACCW-1:0]    pp_ext;
  logic [ACCW-1:0]    acc_sum;
  logic [EW-1:0]      a_ext;
  logic [EW-1:0]      b_ext;
  logic               accept;
  logic               last_step;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .win (b_q[2:0]),
    .m   (m_q),
    .pp  (pp)
  );

  assign a_ext = signed_i ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign b_ext = signed_i ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

  // Partial product is weighted by 4^i; the multiplier shifts down instead
  assign pp_ext  = {{(ACCW-PPW){pp[PPW-1]}}, pp};
  assign acc_sum = acc_q + (pp_ext << {cnt_q, 1'b0});

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_step = (cnt_q == CNTW'(N - 1));

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    case (state_q)
      RUN: begin
        acc_d = acc_sum;
        b_d   = {2'b00, b_q[EW:2]};
        if (last_step) begin
          p_d     = acc_sum[2*WIDTH-1:0];
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        if (accept) begin
          m_d     = a_ext;
          b_d     = {b_ext, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign rdy  = rdy_q;
  assign p    = p_q;

endmodule
